// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the multi-pass shift sequencer.
// Holds the FSM state enum and the shifter control-word packer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int MAX_PASS_AMT = 3;

  function automatic logic [3:0] pack_b(
    input logic       fill,
    input logic [1:0] amt,
    input logic       dir
  );
    return {fill, amt, dir};
  endfunction

endpackage

// File: rtl/arithmetic_shifter.sv
// Single-pass 0-3 position shifter with fill bit.
// B = {fill, amt[1:0], dir}; dir 0 = left, 1 = right.
module arithmetic_shifter #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [3:0]       i_b,
  output logic [WIDTH-1:0] o_x,
  output logic [WIDTH-1:0] o_y
);

  logic             w_fill;
  logic [1:0]       w_amt;
  logic             w_dir;
  logic [WIDTH-1:0] w_ext;
  logic [3*WIDTH-1:0] w_wide;

  assign w_fill = i_b[3];
  assign w_amt  = i_b[2:1];
  assign w_dir  = i_b[0];
  assign w_ext  = {WIDTH{w_fill}};

  // Operand sits in the middle slice; fill enters from the near side,
  // shifted-out bits land in the far slice.
  always_comb begin
    w_wide = '0;
    o_x    = '0;
    o_y    = '0;
    if (!w_dir) begin
      w_wide = {{WIDTH{1'b0}}, i_a, w_ext} << w_amt;
      o_x    = w_wide[2*WIDTH-1:WIDTH];
      o_y    = w_wide[3*WIDTH-1:2*WIDTH];
    end else begin
      w_wide = {w_ext, i_a, {WIDTH{1'b0}}} >> w_amt;
      o_x    = w_wide[2*WIDTH-1:WIDTH];
      o_y    = w_wide[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Round-robin two-requester front end that chains shifter passes
// of up to three positions to realise 0-7 position shifts.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [AMT_W-1:0] req_amt0,
  input  logic [AMT_W-1:0] req_amt1,
  input  logic             req_dir0,
  input  logic             req_dir1,
  input  logic             req_fill0,
  input  logic             req_fill1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_ovf,
  output logic             rsp_id
);

  state_t           r_state;
  logic [WIDTH-1:0] r_work;
  logic [AMT_W-1:0] r_rem;
  logic             r_ovf;
  logic             r_dir;
  logic             r_fill;
  logic             r_id;
  logic             r_last_id;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_ovf;
  logic             r_rsp_id;

  logic [1:0]       w_grant;
  logic             w_acc;
  logic             w_acc_id;
  logic [WIDTH-1:0] w_sel_data;
  logic [AMT_W-1:0] w_sel_amt;
  logic             w_sel_dir;
  logic             w_sel_fill;
  logic [1:0]       w_pass;
  logic [AMT_W-1:0] w_rem_nxt;
  logic [3:0]       w_b;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic             w_ovf_nxt;

  // Both valid: alternate away from the last winner.
  always_comb begin
    w_grant = '0;
    unique case (req_valid)
      2'b11:   w_grant = r_last_id ? 2'b01 : 2'b10;
      2'b10:   w_grant = 2'b10;
      2'b01:   w_grant = 2'b01;
      default: w_grant = '0;
    endcase
  end

  assign req_ready  = (r_state == IDLE) ? w_grant : 2'b00;
  assign w_acc      = |(req_valid & req_ready);
  assign w_acc_id   = req_ready[1];
  assign w_sel_data = w_acc_id ? req_data1 : req_data0;
  assign w_sel_amt  = w_acc_id ? req_amt1  : req_amt0;
  assign w_sel_dir  = w_acc_id ? req_dir1  : req_dir0;
  assign w_sel_fill = w_acc_id ? req_fill1 : req_fill0;

  assign w_pass = (r_rem > AMT_W'(MAX_PASS_AMT))
                ? 2'(MAX_PASS_AMT)
                : r_rem[1:0];
  assign w_rem_nxt = r_rem - AMT_W'(w_pass);
  assign w_b       = pack_b(r_fill, w_pass, r_dir);
  assign w_ovf_nxt = r_ovf | (|w_y);

  arithmetic_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .i_a (r_work),
    .i_b (w_b),
    .o_x (w_x),
    .o_y (w_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_work      <= '0;
      r_rem       <= '0;
      r_ovf       <= 1'b0;
      r_dir       <= 1'b0;
      r_fill      <= 1'b0;
      r_id        <= 1'b0;
      r_last_id   <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_ovf   <= 1'b0;
      r_rsp_id    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_work    <= w_sel_data;
            r_rem     <= w_sel_amt;
            r_dir     <= w_sel_dir;
            r_fill    <= w_sel_fill;
            r_id      <= w_acc_id;
            r_last_id <= w_acc_id;
            r_ovf     <= 1'b0;
            r_state   <= RUN;
          end
        end
        RUN: begin
          r_work <= w_x;
          r_ovf  <= w_ovf_nxt;
          r_rem  <= w_rem_nxt;
          if (w_rem_nxt == '0) begin
            r_state     <= DONE;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_x;
            r_rsp_ovf   <= w_ovf_nxt;
            r_rsp_id    <= r_id;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_ovf   = r_rsp_ovf;
  assign rsp_id    = r_rsp_id;

endmodule
